// File: rtl/bc_level_reader.sv
// rtl/bc_level_reader.sv - raster reader for one box-count level; streams cells and accumulates mass/occupancy
// Defining MOMENT2_EN adds the mass_sq output (sum of squared cell values).
module bc_level_reader #(
  parameter int BOX_IDX  = 3,
  parameter int DATA_LEN = 8,
  parameter int SUM_LEN  = 16
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   BC_mode,
  input  logic                   start,
  input  logic                   level_sel,
  output logic                   rd_en,
  output logic [2*BOX_IDX:0]     rd_addr,
  input  logic [DATA_LEN-1:0]    rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_LEN-1:0]    out_data,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done,
  output logic [SUM_LEN-1:0]     mass,
  output logic [2*BOX_IDX:0]     occupied
`ifdef MOMENT2_EN
  ,
  output logic [2*DATA_LEN+2*BOX_IDX-1:0] mass_sq
`endif
);

  localparam int AW  = 2*BOX_IDX+1;
  localparam int SQW = 2*DATA_LEN+2*BOX_IDX;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;

  logic [BOX_IDX-1:0]  x, y;
  logic                level;
  logic                inflight, inflight_last;
  logic [DATA_LEN-1:0] fifo_data [0:1];
  logic                fifo_last [0:1];
  logic                wptr, rptr;
  logic [1:0]          count;
  logic [2:0]          pending;
  logic                pop, at_end, start_ok;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? fifo_data[rptr] : '0;
  assign out_last  = out_valid & fifo_last[rptr];
  assign at_end    = (&x) & (&y);
  assign start_ok  = (state == S_IDLE) && start;
  // Entries held plus the read still in flight, net of this cycle's pop, must fit the 2-deep buffer.
  assign pending   = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
  assign rd_en     = (state == S_READ) && (pending < 3'd2);
  assign rd_addr   = {x, level, y};
  assign busy      = (state == S_READ) || (state == S_DRAIN);
  assign done      = (state == S_DONE);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_READ;
      S_READ:  if (rd_en && at_end) state_nx = S_DRAIN;
      S_DRAIN: if (pop && out_last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      level         <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else if (BC_mode) begin
      state         <= S_IDLE;
      x             <= '0;
      y             <= '0;
      level         <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      state         <= state_nx;
      inflight      <= rd_en;
      inflight_last <= rd_en & at_end;
      if (start_ok) begin
        x     <= '0;
        y     <= '0;
        level <= level_sel;
      end else if (rd_en) begin
        y <= y + 1'b1;
        if (&y) x <= x + 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else if (BC_mode) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_last[i] <= 1'b0;
      end
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_data[wptr] <= rd_data;
        fifo_last[wptr] <= inflight_last;
        wptr            <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      count <= count + {1'b0, inflight} - {1'b0, pop};
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      mass     <= '0;
      occupied <= '0;
`ifdef MOMENT2_EN
      mass_sq  <= '0;
`endif
    end else if (BC_mode || start_ok) begin
      mass     <= '0;
      occupied <= '0;
`ifdef MOMENT2_EN
      mass_sq  <= '0;
`endif
    end else if (pop) begin
      mass     <= mass + SUM_LEN'(out_data);
      occupied <= occupied + AW'(out_data != '0);
`ifdef MOMENT2_EN
      mass_sq  <= mass_sq + SQW'(out_data) * SQW'(out_data);
`endif
    end
  end

endmodule

// File: tb/tb_bc_level_reader.sv
// tb/tb_bc_level_reader.sv - randomized self-checking bench for bc_level_reader against a raster reference model
module tb_bc_level_reader;

  logic        CLK = 1'b0;
  logic        RST_N, BC_mode, start, level_sel;
  logic        rd_en;
  logic [6:0]  rd_addr;
  logic [7:0]  rd_data;
  logic        out_valid, out_ready, out_last, busy, done;
  logic [7:0]  out_data;
  logic [15:0] mass;
  logic [6:0]  occupied;
`ifdef MOMENT2_EN
  logic [21:0] mass_sq;
`endif

  logic [7:0]  ram [0:127];
  logic        rd_q;
  logic [6:0]  addr_q;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 CLK = ~CLK;

  bc_level_reader dut (
    .CLK(CLK), .RST_N(RST_N), .BC_mode(BC_mode), .start(start), .level_sel(level_sel),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .mass(mass), .occupied(occupied)
`ifdef MOMENT2_EN
    , .mass_sq(mass_sq)
`endif
  );

  // RAM model: one-cycle read latency, garbage on the bus when no read was issued.
  initial begin
    rd_q = 1'b0; addr_q = '0; rd_data = '0;
  end
  always @(negedge CLK) begin
    rd_q   = rd_en;
    addr_q = rd_addr;
  end
  always @(posedge CLK) begin
    #1;
    rd_data = rd_q ? ram[addr_q] : 8'($urandom);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    logic [63:0] v;
    v = 64'({rd_en, rd_addr, out_valid, out_data, out_last, busy, done, mass, occupied});
`ifdef MOMENT2_EN
    v = v | 64'(mass_sq);
`endif
    return v;
  endfunction

  // kind 0: level1 cell = x*8+y; 1: level0 all 255; 2: random with zeros; 3: level1 all zero
  task automatic fill(input int kind);
    for (int a = 0; a < 128; a++) begin
      logic [6:0] ad;
      logic [7:0] v;
      ad = a[6:0];
      v  = 8'($urandom);
      case (kind)
        0: if (ad[3]) v = 8'(int'(ad[6:4]) * 8 + int'(ad[2:0]));
        1: if (!ad[3]) v = 8'd255;
        2: if ($urandom_range(0, 3) == 0) v = 8'd0;
        3: if (ad[3]) v = 8'd0;
        default: ;
      endcase
      ram[a] = v;
    end
  endtask

  function automatic logic ready_for(input int rmode, input int cyc);
    if (rmode == 0) return 1'b1;
    if (rmode == 1) return cyc[0];
    return 1'($urandom_range(0, 1));
  endfunction

  // abort 0: full scan; 1: async reset after 20 transfers; 2: BC_mode asserted in DRAIN
  task automatic run_scan(input logic lvl, input int rmode, input int abort);
    logic [7:0]  exp_q [$];
    longint      m_exp, o_exp, sq_exp;
    int          idx, first_rd, first_ov, done_cnt, done_cyc;
    logic        pv, pr, pl, last_seen;
    logic [7:0]  pd;
    exp_q.delete();
    m_exp = 0; o_exp = 0; sq_exp = 0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        logic [6:0] ad;
        ad = {x[2:0], lvl, y[2:0]};
        exp_q.push_back(ram[ad]);
        m_exp  += ram[ad];
        o_exp  += (ram[ad] != 0) ? 1 : 0;
        sq_exp += ram[ad] * ram[ad];
      end

    @(posedge CLK); #1;
    start = 1'b1; level_sel = lvl; out_ready = ready_for(rmode, 0);
    @(negedge CLK);
    idx = 0; first_rd = -1; first_ov = -1; done_cnt = 0; done_cyc = -1;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; last_seen = 1'b0;

    for (int cyc = 1; cyc < 400 && done_cnt == 0; cyc++) begin
      @(posedge CLK); #1;
      start     = (rmode == 2 && cyc == 10);
      level_sel = 1'($urandom);
      out_ready = ready_for(rmode, cyc);
      @(negedge CLK);
      if (cyc == 1) chk("busy_after_start", busy, 1);
      if (rd_en) begin
        if (first_rd < 0) first_rd = cyc;
        chk("rd_level_bit", rd_addr[3], lvl);
        if (rd_addr[6:4] == 3'd7 && rd_addr[2:0] == 3'd7) last_seen = 1'b1;
      end
      if (out_valid && first_ov < 0) first_ov = cyc;
      if (pv && !pr) chk("stall_hold", {out_valid, out_last, out_data}, {1'b1, pl, pd});
      if (out_valid && out_ready) begin
        if (idx < 64) begin
          chk("cell_data", out_data, exp_q[idx]);
          chk("cell_last", out_last, idx == 63);
        end else begin
          chk("extra_transfer", idx, 63);
        end
        idx++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;

      if (abort == 1 && idx == 20) begin
        #2 RST_N = 1'b0;
        #1 chk("async_reset_outs", all_outs(), 0);
        start = 1'b0; out_ready = 1'b1;
        @(posedge CLK); #1;
        chk("reset_hold_outs", all_outs(), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        return;
      end
      if (abort == 2 && last_seen) begin
        @(posedge CLK); #1;
        BC_mode = 1'b1; start = 1'b1;
        @(posedge CLK); #1;
        BC_mode = 1'b0; start = 1'b0;
        @(negedge CLK);
        chk("bcmode_clear", {busy, done, out_valid, rd_en, mass, occupied}, 0);
        done_cnt = 0;
        repeat (5) begin
          @(negedge CLK);
          if (done) done_cnt++;
          chk("bcmode_idle_busy", busy, 0);
        end
        chk("bcmode_no_done", done_cnt, 0);
        return;
      end
    end

    if (done_cnt == 0) begin
      chk("scan_timeout", 0, 1);
    end else begin
      chk("transfer_count", idx, 64);
      chk("mass", mass, m_exp);
      chk("occupied", occupied, o_exp);
`ifdef MOMENT2_EN
      chk("mass_sq", mass_sq, sq_exp);
`endif
      chk("busy_at_done", busy, 0);
      if (rmode == 0) begin
        chk("first_rd_cycle", first_rd, 1);
        chk("first_valid_cycle", first_ov, 3);
        chk("done_cycle", done_cyc, 67);
      end
      done_cnt = 0;
      repeat (3) begin
        @(negedge CLK);
        if (done) done_cnt++;
      end
      chk("done_single_pulse", done_cnt, 0);
      chk("mass_hold", mass, m_exp);
      chk("occupied_hold", occupied, o_exp);
    end
  endtask

  initial begin
    RST_N = 1'b0; BC_mode = 1'b0; start = 1'b0; level_sel = 1'b0; out_ready = 1'b0;
    fill(2);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("reset_state", all_outs(), 0);
    RST_N = 1'b1;

    fill(0);
    run_scan(1'b1, 0, 0);
    run_scan(1'b1, 1, 0);
    fill(1);
    run_scan(1'b0, 0, 0);
    fill(2);
    run_scan(1'b1, 2, 1);
    run_scan(1'b1, 0, 0);
    fill(2);
    run_scan(1'b0, 0, 2);
    run_scan(1'b0, 2, 0);
    fill(3);
    run_scan(1'b1, 2, 0);
    for (int k = 0; k < 3; k++) begin
      fill(2);
      run_scan(1'($urandom), 2, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
